// File: rtl/carro_secuenciador.sv
// carro_secuenciador
// Control sequencer for one car object. Issues load / step / jump commands to
// the car position register, paces steps with a programmable divider, wraps the
// car at the bottom of the screen, counts laps and reports game-over on a hit.
//
// Ports:
//   iClk        system clock, rising edge
//   iReset_n    asynchronous active-low reset
//   iStart      start / restart request
//   iPausa      freezes the step divider while high
//   iColision   collision flag from the hit detector
//   iVelocidad  speed select, step period = STEP_DIV >> iVelocidad
//   iPosicionY  current car Y fed back from the position register
//   oEnable     one-cycle pulse: load initial position
//   oSuma       one-cycle pulse: Y + 1
//   oSalto      one-cycle pulse: jump to auxiliary position
//   oActivo     high in LOAD, RUN and WRAP
//   oFin        high in HIT (game over)
//   oReinicios  saturating wrap count
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for the first start request
// LOAD  | one cycle, loads initial position, clears divider and laps
// RUN   | stepping the car one row per divider period
// WRAP  | one cycle, jumps the car back to the top, counts a lap
// HIT   | game over, waiting for a restart request

module carro_secuenciador #(
  parameter logic [31:0] STEP_DIV = 32'd833333,
  parameter logic [8:0]  Y_LIMIT  = 9'd479
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iStart,
  input  logic       iPausa,
  input  logic       iColision,
  input  logic [1:0] iVelocidad,
  input  logic [8:0] iPosicionY,
  output logic       oEnable,
  output logic       oSuma,
  output logic       oSalto,
  output logic       oActivo,
  output logic       oFin,
  output logic [7:0] oReinicios
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WRAP, HIT} tState;

  tState       state;
  tState       stateNext;
  logic [31:0] divCnt;
  logic [31:0] divNext;
  logic [31:0] period;
  logic [31:0] periodNext;
  logic [31:0] periodSel;
  logic        boundary;
  logic        enableNext;
  logic        sumaNext;
  logic        saltoNext;
  logic        activoNext;
  logic        finNext;
  logic [7:0]  reiniciosNext;

  assign periodSel = STEP_DIV >> iVelocidad;
  // A paused cycle is never a boundary, so a pause delays every later step by
  // exactly its length even when it starts on the last cycle of a period.
  assign boundary  = (state == RUN) && !iPausa && (divCnt == period - 32'd1);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (iStart) stateNext = LOAD;
      LOAD: stateNext = RUN;
      RUN: begin
        if (iColision) begin
          stateNext = HIT;
        end else if (boundary && (iPosicionY >= Y_LIMIT)) begin
          stateNext = WRAP;
        end
      end
      WRAP: stateNext = iColision ? HIT : RUN;
      HIT:  if (iStart) stateNext = LOAD;
      default: stateNext = IDLE;
    endcase
  end

  // Every output is registered: its next value is derived from the state being
  // entered, so the pulse appears exactly in the cycle of that state.
  always_comb begin
    enableNext    = (stateNext == LOAD);
    saltoNext     = (stateNext == WRAP);
    activoNext    = (stateNext == LOAD) || (stateNext == RUN) || (stateNext == WRAP);
    finNext       = (stateNext == HIT);
    // A collision on a step boundary wins over the step.
    sumaNext      = boundary && !iColision && (iPosicionY < Y_LIMIT);
    reiniciosNext = oReinicios;
    if (stateNext == LOAD) begin
      reiniciosNext = 8'd0;
    end else if ((stateNext == WRAP) && (oReinicios != 8'hFF)) begin
      reiniciosNext = oReinicios + 8'd1;
    end

    divNext    = divCnt;
    periodNext = period;
    case (state)
      LOAD: begin
        divNext    = 32'd0;
        periodNext = periodSel;
      end
      RUN: begin
        if (boundary) begin
          divNext    = 32'd0;
          periodNext = periodSel;
        end else if (!iPausa) begin
          divNext = divCnt + 32'd1;
        end
      end
      WRAP: divNext = 32'd0;
      default: ;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      divCnt     <= 32'd0;
      period     <= STEP_DIV;
      oEnable    <= 1'b0;
      oSuma      <= 1'b0;
      oSalto     <= 1'b0;
      oActivo    <= 1'b0;
      oFin       <= 1'b0;
      oReinicios <= 8'd0;
    end else begin
      divCnt     <= divNext;
      period     <= periodNext;
      oEnable    <= enableNext;
      oSuma      <= sumaNext;
      oSalto     <= saltoNext;
      oActivo    <= activoNext;
      oFin       <= finNext;
      oReinicios <= reiniciosNext;
    end
  end

endmodule
